ssd1306_stream_ctrl: RTL and testbench

Parametrised SSD1306 OLED controller with an integrated SPI mode-0 byte serialiser. It drives the panel's hardware reset and plays a power-on command sequence from an external command ROM. On demand, or continuously, it streams a full frame from an external page-major framebuffer RAM. It sits between the display framebuffer and the OLED pins: `o_SPI_Clk`/D0, `o_SPI_MOSI`/D1, `o_DC`, `o_RES_n`, `o_SPI_CS_n`.

---
 rtl/ssd1306_stream_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ssd1306_stream_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_stream_ctrl.sv
// SSD1306 OLED controller: panel reset, ROM-driven init, frame streaming over SPI mode 0.
// Define SSD1306_STREAM_CONTINUOUS_EN to stream frames back-to-back without i_Frame_Start.
module ssd1306_stream_ctrl #(
  parameter int WIDTH             = 128,
  parameter int PAGES             = 8,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int INIT_LEN          = 26,
  parameter int FRAME_CMD_LEN     = 6,
  parameter int RESET_CLKS        = 16
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Frame_Start,
  output logic [7:0]  o_Cmd_Addr,
  input  logic [7:0]  i_Cmd_Byte,
  output logic [15:0] o_Fb_Addr,
  input  logic [7:0]  i_Fb_Byte,
  output logic        o_SPI_Clk,
  output logic        o_SPI_MOSI,
  output logic        o_SPI_CS_n,
  output logic        o_DC,
  output logic        o_RES_n,
  output logic        o_Ready,
  output logic        o_Frame_Done
);

  localparam int FB_BYTES = WIDTH * PAGES;
  localparam int AW = (FB_BYTES > 1) ? $clog2(FB_BYTES) : 1;
  localparam int HW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam int RW = (RESET_CLKS > 1) ? $clog2(RESET_CLKS) : 1;

`ifdef SSD1306_STREAM_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef enum logic [2:0] {RST_LOW, RST_WAIT, INIT, IDLE, FCMD, FDATA} phase_t;
  typedef enum logic [1:0] {E_LOAD, E_BITS, E_FETCH, E_GAP} eng_t;

  phase_t          phase;
  eng_t            eng;
  logic [RW-1:0]   rst_cnt;
  logic [HW-1:0]   half_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      cmd_addr;
  logic [AW-1:0]   fb_addr;
  logic            sclk, cs_n, dc, res_n, ready, frame_done;
  logic [7:0]      byte_in;
  logic            last_byte;

  assign byte_in = (phase == FDATA) ? i_Fb_Byte : i_Cmd_Byte;

  always_comb begin
    last_byte = 1'b0;
    case (phase)
      INIT:    last_byte = (cmd_addr == 8'(INIT_LEN - 1));
      FCMD:    last_byte = (cmd_addr == 8'(INIT_LEN + FRAME_CMD_LEN - 1));
      FDATA:   last_byte = (fb_addr == AW'(FB_BYTES - 1));
      default: last_byte = 1'b0;
    endcase
  end

  // In the LOAD cycle the shift register is not yet filled, so bit 7 comes straight from the source.
  assign o_SPI_MOSI   = (eng == E_LOAD && !cs_n) ? byte_in[7] : shreg[7];
  assign o_SPI_Clk    = sclk;
  assign o_SPI_CS_n   = cs_n;
  assign o_DC         = dc;
  assign o_RES_n      = res_n;
  assign o_Ready      = ready;
  assign o_Frame_Done = frame_done;
  assign o_Cmd_Addr   = cmd_addr;
  assign o_Fb_Addr    = 16'(fb_addr);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      phase      <= RST_LOW;
      eng        <= E_GAP;
      rst_cnt    <= '0;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      cmd_addr   <= '0;
      fb_addr    <= '0;
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
      dc         <= 1'b0;
      res_n      <= 1'b0;
      ready      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (phase)
        RST_LOW: begin
          if (rst_cnt == RW'(RESET_CLKS - 1)) begin
            rst_cnt <= '0;
            res_n   <= 1'b1;
            phase   <= RST_WAIT;
          end else rst_cnt <= rst_cnt + 1'b1;
        end
        RST_WAIT: begin
          if (rst_cnt == RW'(RESET_CLKS - 1)) begin
            rst_cnt <= '0;
            phase   <= INIT;
            eng     <= E_LOAD;
            cs_n    <= 1'b0;
            dc      <= 1'b0;
          end else rst_cnt <= rst_cnt + 1'b1;
        end
        IDLE: begin
          if (i_Frame_Start && !CONT) begin
            phase <= FCMD;
            eng   <= E_LOAD;
            cs_n  <= 1'b0;
            dc    <= 1'b0;
            ready <= 1'b0;
          end
        end
        default: begin
          case (eng)
            E_LOAD: begin
              shreg    <= byte_in;
              eng      <= E_BITS;
              half_cnt <= '0;
              bit_cnt  <= '0;
            end
            E_BITS: begin
              if (half_cnt == HW'(CLKS_PER_HALF_BIT - 1)) begin
                half_cnt <= '0;
                if (!sclk) sclk <= 1'b1;
                else begin
                  sclk <= 1'b0;
                  if (bit_cnt != 3'd7) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shreg   <= {shreg[6:0], 1'b0};
                  end else begin
                    // Byte complete: advance the source address so it is presented during FETCH.
                    if (phase == FDATA) fb_addr <= last_byte ? '0 : fb_addr + 1'b1;
                    else cmd_addr <= (phase == FCMD && last_byte) ? 8'(INIT_LEN) : cmd_addr + 8'd1;
                    if (last_byte) begin
                      cs_n <= 1'b1;
                      eng  <= E_GAP;
                      if (phase == FDATA) frame_done <= 1'b1;
                    end else eng <= E_FETCH;
                  end
                end
              end else half_cnt <= half_cnt + 1'b1;
            end
            E_FETCH: eng <= E_LOAD;
            default: begin
              if (phase == FCMD) begin
                phase <= FDATA;
                eng   <= E_LOAD;
                cs_n  <= 1'b0;
                dc    <= 1'b1;
              end else if (CONT) begin
                phase <= FCMD;
                eng   <= E_LOAD;
                cs_n  <= 1'b0;
                dc    <= 1'b0;
              end else begin
                phase <= IDLE;
                ready <= 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1306_stream_ctrl.sv
// Directed bench for ssd1306_stream_ctrl: SPI monitor pops a scoreboard of expected {dc, byte}.
module tb_ssd1306_stream_ctrl;
  localparam int W = 16, P = 2, CPHB = 1, IL = 26, FL = 6, RC = 16;
  localparam int PERIOD = 16 * CPHB + 2;
  localparam int FRAME = FL + W * P;

  logic        clk = 1'b0, rst = 1'b1, fs = 1'b0;
  logic [7:0]  cmd_addr, cmd_byte, fb_byte;
  logic [15:0] fb_addr;
  logic        sclk, mosi, cs_n, dc, res_n, ready, done;

  ssd1306_stream_ctrl #(
    .WIDTH(W), .PAGES(P), .CLKS_PER_HALF_BIT(CPHB),
    .INIT_LEN(IL), .FRAME_CMD_LEN(FL), .RESET_CLKS(RC)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Frame_Start(fs),
    .o_Cmd_Addr(cmd_addr), .i_Cmd_Byte(cmd_byte),
    .o_Fb_Addr(fb_addr), .i_Fb_Byte(fb_byte),
    .o_SPI_Clk(sclk), .o_SPI_MOSI(mosi), .o_SPI_CS_n(cs_n),
    .o_DC(dc), .o_RES_n(res_n), .o_Ready(ready), .o_Frame_Done(done)
  );

  always #5 clk = ~clk;

  assign cmd_byte = cmd_addr ^ 8'hA5;
  always @(posedge clk) fb_byte <= 8'(fb_addr + 16'd1);

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [8:0] exp_q[$];
  task automatic push_init();
    for (int i = 0; i < IL; i++) exp_q.push_back({1'b0, 8'(i) ^ 8'hA5});
  endtask
  task automatic push_frame();
    for (int i = 0; i < FL; i++) exp_q.push_back({1'b0, 8'(IL + i) ^ 8'hA5});
    for (int i = 0; i < W * P; i++) exp_q.push_back({1'b1, 8'(i + 1)});
  endtask

  // SPI monitor: samples on the falling system edge, captures MOSI at each SCLK rise.
  int bitc = 0, bytes_rx = 0, n_done = 0, cs_rises = 0, last_cyc = 0;
  logic [7:0] sh;
  logic prev_sclk = 1'b0, prev_cs = 1'b1, dc0 = 1'b0, last_dc = 1'b0;
  bit last_ok = 1'b0, saw_ready = 1'b0;
  always @(negedge clk) begin
    if (cs_n) bitc = 0;
    else if (sclk && !prev_sclk) begin
      if (bitc == 0) dc0 = dc;
      sh = {sh[6:0], mosi};
      bitc++;
      if (bitc == 8) begin
        bitc = 0;
        bytes_rx++;
        if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 1);
        else begin
          chk("spi_byte", 32'({dc, sh}), 32'(exp_q.pop_front()));
          chk("dc_stable", 32'(dc), 32'(dc0));
          if (dc && last_dc && last_ok) chk("byte_period", cyc - last_cyc, PERIOD);
          last_dc = dc;
          last_cyc = cyc;
          last_ok = 1'b1;
        end
      end
    end
    if (cs_n && !prev_cs) cs_rises++;
    if (done) n_done++;
    if (ready) saw_ready = 1'b1;
    prev_sclk = sclk;
    prev_cs = cs_n;
  end

  initial begin
    int k, cnt, rx0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_dc", 32'(dc), 0);
    chk("rst_res_n", 32'(res_n), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cmd_addr", 32'(cmd_addr), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);

    push_init();
    rst = 1'b0;
    cnt = 0;
    while (!res_n && cnt < 100) begin
      if (!cs_n) chk("cs_in_rst_low", 32'(cs_n), 1);
      cnt++;
      @(negedge clk);
    end
    chk("res_low_cycles", cnt, RC);
    cnt = 0;
    while (res_n && cs_n && !sclk && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("res_wait_cycles", cnt, RC);
    k = 0;
    while (!sclk && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk("first_rise_after_wait", 32'(cnt + k >= RC), 1);

`ifdef SSD1306_STREAM_CONTINUOUS_EN
    push_frame();
    push_frame();
    push_frame();
    for (int f = 0; f < 2; f++) begin
      k = 0;
      while (!done && k < 5000) begin
        k++;
        @(negedge clk);
      end
      chk("cont_done_seen", 32'(done), 1);
      chk("cont_done_cs", 32'(cs_n), 1);
      @(negedge clk);
      chk("cont_gap_1cycle", 32'(cs_n), 0);
      chk("cont_dc_cmd", 32'(dc), 0);
    end
    chk("cont_bytes", bytes_rx, IL + 2 * FRAME);
    chk("cont_done_count", n_done, 2);
    chk("cont_never_ready", 32'(saw_ready), 0);
`else
    k = 0;
    while (!ready && k < 2000) begin
      k++;
      @(negedge clk);
    end
    chk("init_ready", 32'(ready), 1);
    chk("init_bytes", bytes_rx, IL);
    chk("init_q_empty", exp_q.size(), 0);
    chk("init_cs_contig", cs_rises, 1);

    // One frame, with a stray start pulse during FDATA.
    push_frame();
    cs_rises = 0;
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    chk("frame_busy", 32'(ready), 0);
    k = 0;
    while (bytes_rx < IL + FL + 4 && k < 2000) begin
      k++;
      @(negedge clk);
    end
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    k = 0;
    while (!done && k < 2000) begin
      k++;
      @(negedge clk);
    end
    chk("done_seen", 32'(done), 1);
    chk("done_cs", 32'(cs_n), 1);
    chk("done_ready", 32'(ready), 0);
    @(negedge clk);
    chk("ready_after_done", 32'(ready), 1);
    chk("done_single", 32'(done), 0);
    chk("frame_q_empty", exp_q.size(), 0);
    chk("frame_bytes", bytes_rx, IL + FRAME);
    chk("frame_cs_rises", cs_rises, 2);
    chk("fb_addr_wrap", 32'(fb_addr), 0);
    repeat (100) @(negedge clk);
    chk("no_queued_frame", bytes_rx, IL + FRAME);
    chk("done_count", n_done, 1);
    chk("idle_cs", 32'(cs_n), 1);

    // Reset in the middle of a data byte.
    push_frame();
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    k = 0;
    while (!(dc && bitc == 3) && k < 3000) begin
      k++;
      @(negedge clk);
    end
    chk("reach_mid_byte", 32'(k < 3000), 1);
    rst = 1'b1;
    exp_q.delete();
    rx0 = bytes_rx;
    @(negedge clk);
    chk("midrst_cs_n", 32'(cs_n), 1);
    chk("midrst_sclk", 32'(sclk), 0);
    chk("midrst_res_n", 32'(res_n), 0);
    chk("midrst_ready", 32'(ready), 0);
    rst = 1'b0;
    push_init();
    k = 0;
    while (!ready && k < 3000) begin
      k++;
      @(negedge clk);
    end
    chk("replay_ready", 32'(ready), 1);
    chk("replay_bytes", bytes_rx, rx0 + IL);
    chk("replay_q_empty", exp_q.size(), 0);

    // Reset and frame start together: the request is dropped.
    rst = 1'b1;
    fs = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fs = 1'b0;
    chk("rst_fs_res_n", 32'(res_n), 0);
    chk("rst_fs_cs_n", 32'(cs_n), 1);
    rx0 = bytes_rx;
    push_init();
    k = 0;
    while (!ready && k < 3000) begin
      k++;
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    chk("rst_fs_dropped", bytes_rx, rx0 + IL);
    chk("rst_fs_ready", 32'(ready), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
